referee_rr: RTL

//  Parametrised flow-control referee between N_SRC show-ahead source FIFOs and N_DST destination FIFOs.
//  - Arbitrates sources round-robin with a per-grant burst quantum.
//  - Routes each head word to the destination selected by its DST field.
//  - Backpressure comes from destination almost_full.
//  - Generalises the single-pop/multi-push referee; sits between the TLP class FIFOs.

---
 rtl/referee_pkg.sv | 23 ++
 rtl/referee_rr_arb.sv | 34 +++
 rtl/referee_rr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/referee_pkg.sv
// Shared definitions for the referee family: FSM encodings, default word layout and a
// width helper used to size index fields.
package referee_pkg;

  // Default word layout shared with the other referees.
  localparam int unsigned DefaultDw     = 10;
  localparam int unsigned DefaultDstLsb = 8;

  // FSM encodings.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  // Ceiling log2, never below 1 so that single-entry indices still get a real bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/referee_rr_arb.sv
// Combinational rotating-priority arbiter: the first eligible requester at or after
// `pointer` (wrapping) wins. The pointer itself is owned by the parent.
module referee_rr_arb
  import referee_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  // Scan from the pointer outward and keep only the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(pointer) + k) % N);
      if (!any && eligible[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/referee_rr.sv
// Round-robin flow-control referee between N_SRC show-ahead source FIFOs and N_DST
// destination FIFOs. One pop per cycle at most; the popped word is pushed to the
// destination named by its DST field one cycle later.
// Optional statistics (per-destination push counters, drop counter) are built when
// REFEREE_STATS_EN is defined.
module referee_rr
  import referee_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned N_DST   = 4,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned DST_LSB = DefaultDstLsb,
  parameter int unsigned QUANTUM = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_empty,
  input  logic [N_SRC*DW-1:0]        src_data,
  output logic [N_SRC-1:0]           src_pop,
  input  logic [N_DST-1:0]           dst_almost_full,
  output logic [N_DST-1:0]           dst_push,
  output logic [DW-1:0]              dst_data,
  output logic [clog2(N_SRC)-1:0]    grant_id,
  output logic                       err_drop,
`ifdef REFEREE_STATS_EN
  output logic [32*N_DST-1:0]        push_count,
  output logic [15:0]                drop_count,
`endif
  output logic                       idle
);

  localparam int unsigned SW   = clog2(N_SRC);
  localparam int unsigned DSTW = clog2(N_DST);
  localparam int unsigned CW   = clog2(QUANTUM + 1);

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    grant_q, grant_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    rot_ptr, arb_ptr, arb_idx, pop_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_SRC-1:0] eligible, arb_grant, pop_d;
  logic             arb_any, pop_any;
  logic [DSTW-1:0]  src_dst [N_SRC];

  logic [DW-1:0]    head_word;
  logic [DSTW-1:0]  head_dst;
  logic             head_in_range;

  // The single word in flight between its pop and its push.
  logic             pend_valid_q, pend_err_q;
  logic [DW-1:0]    pend_data_q;
  logic [DSTW-1:0]  pend_dst_q;
  logic [N_DST-1:0] push_d;

  // A source may be popped only if it has a word and its destination can take it.
  // Out-of-range destinations are always eligible so the word gets drained and flagged.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_dst[i]  = src_data[i*DW + DST_LSB +: DSTW];
      eligible[i] = !src_empty[i] &&
                    ((32'(src_dst[i]) >= N_DST) || !dst_almost_full[src_dst[i]]);
    end
  end

  // On rotation the search restarts just past the current grant; from idle it uses
  // the stored pointer.
  always_comb begin
    rot_ptr = (32'(grant_q) == N_SRC - 1) ? '0 : grant_q + 1'b1;
    arb_ptr = (state_q == StXfer) ? rot_ptr : ptr_q;
  end

  referee_rr_arb #(
    .N  (N_SRC),
    .IW (SW)
  ) u_arb (
    .eligible  (eligible),
    .pointer   (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // FSM: keep popping the granted source until its quantum expires or it stalls, then
  // rotate and re-arbitrate in the same cycle so a lone source sees no gap.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pop_d   = '0;
    pop_any = 1'b0;
    pop_idx = grant_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d = StXfer;
          grant_d = arb_idx;
          cnt_d   = CW'(1);
          pop_any = 1'b1;
          pop_idx = arb_idx;
          pop_d   = arb_grant;
        end
      end
      StXfer: begin
        if (eligible[grant_q] && (cnt_q < CW'(QUANTUM))) begin
          cnt_d          = cnt_q + 1'b1;
          pop_any        = 1'b1;
          pop_d[grant_q] = 1'b1;
        end else begin
          ptr_d = rot_ptr;
          if (arb_any) begin
            grant_d = arb_idx;
            cnt_d   = CW'(1);
            pop_any = 1'b1;
            pop_idx = arb_idx;
            pop_d   = arb_grant;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the head word of whichever source is being popped.
  always_comb begin
    head_word = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (32'(pop_idx) == i) head_word = src_data[i*DW +: DW];
    end
  end

  assign head_dst      = head_word[DST_LSB +: DSTW];
  assign head_in_range = 32'(head_dst) < N_DST;

  // Decode the in-flight word into a one-hot push; dropped words never push.
  always_comb begin
    push_d = '0;
    if (pend_valid_q && !pend_err_q) push_d[pend_dst_q] = 1'b1;
  end

  // State, in-flight word and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      src_pop      <= '0;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_data_q  <= '0;
      pend_dst_q   <= '0;
      dst_push     <= '0;
      dst_data     <= '0;
      err_drop     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      src_pop      <= pop_d;
      pend_valid_q <= pop_any;
      if (pop_any) begin
        pend_data_q <= head_word;
        pend_dst_q  <= head_dst;
        pend_err_q  <= !head_in_range;
      end
      dst_push     <= push_d;
      dst_data     <= pend_data_q;
      err_drop     <= pend_valid_q && pend_err_q;
    end
  end

  assign grant_id = grant_q;
  assign idle     = (state_q == StIdle) && !pend_valid_q && (dst_push == '0) && !err_drop;

`ifdef REFEREE_STATS_EN
  // Saturating per-destination push counters and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_count <= '0;
      drop_count <= '0;
    end else begin
      for (int unsigned d = 0; d < N_DST; d++) begin
        if (dst_push[d] && (push_count[d*32 +: 32] != '1)) begin
          push_count[d*32 +: 32] <= push_count[d*32 +: 32] + 32'd1;
        end
      end
      if (err_drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
